// File: rtl/flag_scanner.sv
// Walks a captured comparator flag vector and emits the index of each mismatching channel.
// Optional FLAG_SCAN_BIT0_EN: also scan and emit the reference channel (bit 0).
module flag_scanner #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [WIDTH-1:0] flag_in,
  output logic [IDXW-1:0] idx_out,
  output logic            idx_valid,
  input  logic            idx_ready,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] err_count,
  output logic            all_match
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [IDXW-1:0] LAST_PTR = IDXW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(WIDTH);
`ifdef FLAG_SCAN_BIT0_EN
  localparam logic [IDXW-1:0]  FIRST_PTR = '0;
  localparam logic [WIDTH-1:0] CAP_MASK  = '1;
`else
  localparam logic [IDXW-1:0]  FIRST_PTR = IDXW'(1);
  localparam logic [WIDTH-1:0] CAP_MASK  = ~WIDTH'(1);
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] snapshot_reg, snapshot_next;
  logic [IDXW-1:0]  ptr_reg, ptr_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;
  logic             match_reg, match_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      snapshot_reg <= '0;
      ptr_reg      <= FIRST_PTR;
      idx_reg      <= '0;
      valid_reg    <= 1'b0;
      cnt_reg      <= '0;
      match_reg    <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      snapshot_reg <= snapshot_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      valid_reg    <= valid_next;
      cnt_reg      <= cnt_next;
      match_reg    <= match_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    snapshot_next = snapshot_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    cnt_next      = cnt_reg;
    match_next    = match_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        // busy_reg still covers the done cycle, so a start there is dropped
        if (start && !busy_reg) begin
          snapshot_next = flag_in & CAP_MASK;
          ptr_next      = FIRST_PTR;
          cnt_next      = '0;
          state_next    = SCAN;
        end
      end
      SCAN: begin
        if (snapshot_reg[ptr_reg]) begin
          idx_next   = ptr_reg;
          valid_next = 1'b1;
          state_next = EMIT;
        end else if (ptr_reg == LAST_PTR) begin
          state_next = DONE;
        end else begin
          ptr_next = ptr_reg + IDXW'(1);
        end
      end
      EMIT: begin
        if (idx_ready) begin
          valid_next = 1'b0;
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNTW'(1);
          if (ptr_reg == LAST_PTR) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr_reg + IDXW'(1);
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        done_next  = 1'b1;
        match_next = (cnt_reg == '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // done and all_match are registered, so busy is stretched to cover their cycle
    busy_next = (state_next != IDLE) || (state_reg == DONE);
  end

  assign idx_out   = idx_reg;
  assign idx_valid = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_count = cnt_reg;
  assign all_match = match_reg;

endmodule

// File: doc/flag_scanner.md
Name: flag_scanner

Overview:
- Sequential consumer of the 8-bit Flag vector produced by the multi-input equality comparator. Bit 0 is the reference channel; bits 1..7 are set on mismatch.
- On a start pulse it snapshots the vector and walks bits 1..7 in ascending order.
- It emits the index of each set bit over a valid/ready handshake and keeps a running mismatch count.
- When the walk ends it pulses done and reports whether every channel matched Din0.

Parameters:
WIDTH, 8, number of flag bits (channel 0 = reference).
IDXW, 3, width of the emitted index (log2 of WIDTH).
CNTW, 4, width of the mismatch counter (holds 0..WIDTH).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a scan; sampled only in IDLE.
flag_in  input  WIDTH  flag vector from the comparator; captured on the accepted start edge.
idx_out  output  IDXW  index of the current mismatching channel; meaningful while idx_valid=1.
idx_valid  output  1  idx_out holds an unconsumed index.
idx_ready  input  1  downstream accepts idx_out; transfer occurs when idx_valid and idx_ready are both 1 at a rising edge.
busy  output  1  high from the edge after start is accepted until the DONE state exits.
done  output  1  single-cycle pulse at end of scan.
err_count  output  CNTW  number of indices transferred in the last or current scan.
all_match  output  1  1 when the last completed scan found zero mismatches.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; snapshot=0; ptr=1; idx_out=0; idx_valid=0; busy=0; done=0; err_count=0; all_match=0. Reset mid-scan aborts immediately; no done is issued.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - busy=0.
  - When start=1: snapshot<=flag_in with bit 0 forced to 0; ptr<=1; err_count<=0; next state SCAN.
- SCAN (one bit examined per cycle, busy=1):
  - If snapshot[ptr]=1: idx_out<=ptr; idx_valid<=1; next state EMIT.
  - Else if ptr=WIDTH-1: next state DONE.
  - Else ptr<=ptr+1.
- EMIT:
  - idx_valid and idx_out are held stable until the handshake.
  - On the handshake: idx_valid<=0; err_count<=err_count+1.
  - After the handshake, if ptr=WIDTH-1 next state DONE; else ptr<=ptr+1 and next state SCAN.
  - idx_ready has no effect outside EMIT.
- DONE:
  - done=1 for exactly one cycle; all_match<=(err_count==0); busy=1 during this cycle.
  - Next state IDLE.
- Timing:
  - With zero mismatches, done is high in the cycle following the 8th rising edge after the edge that accepted start.
  - Each mismatch adds one EMIT cycle plus any cycles with idx_ready=0.
- start while busy: ignored; it is not queued.
- flag_in changes after capture have no effect on the current scan.
- err_count saturates at WIDTH; overflow cannot occur at the default widths.
- err_count and all_match hold their values until the next accepted start. all_match is not cleared at start; it updates only in DONE.
- Indices are always emitted in strictly ascending order, with no duplicates.

Optional Feature:
FLAG_SCAN_BIT0_EN:
- Defined:
  - Bit 0 of flag_in is captured unmasked.
  - ptr starts at 0, and bit 0 is scanned and emitted like any other channel.
  - Maximum err_count is 8.
  - The zero-mismatch done latency becomes 9 edges.
- Undefined: bit 0 is masked and never emitted, as described above.

Test Plan:
- flag_in=8'h00, start pulse, idx_ready=1: no idx_valid; done pulses 8 edges after start; err_count=0; all_match=1.
- flag_in=8'h20, idx_ready=1: exactly one transfer with idx_out=5; then done; err_count=1; all_match=0.
- flag_in=8'hFE, idx_ready toggling 0/1 every cycle: idx_out sequence is 1,2,3,4,5,6,7, each held stable while ready=0; err_count=7; all_match=0.
- flag_in=8'h81, idx_ready=1: only idx 7 is emitted (bit 0 masked); err_count=1.
- A start pulse during SCAN with a different flag_in: ignored; the original snapshot's results complete; no second done.
- rst_n low while in EMIT with idx_valid=1: all outputs return to reset values asynchronously; no done; a new start then scans normally. Also run with FLAG_SCAN_BIT0_EN defined and flag_in=8'h01: idx 0 is emitted; err_count=1.
